// File: rtl/sd_spi_responder_pkg.sv
// Shared definitions for the SD/SPI card responder: command indices, R1 layout,
// data token and the command FSM state encoding.
package sd_spi_pkg;
  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD16  = 6'd16;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] CMD58  = 6'd58;
  localparam logic [5:0] ACMD41 = 6'd41;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;

  localparam logic [7:0] DATA_TOKEN = 8'hFE;
  localparam logic [8:0] BLK_LAST   = 9'd511;

  typedef enum logic [2:0] {
    ST_HUNT, ST_CMD, ST_NCR, ST_RESP, ST_RDWAIT, ST_TOKEN, ST_DATA, ST_CRC
  } sd_state_e;

  function automatic logic [7:0] r1_byte(input logic illegal, input logic idle);
    logic [7:0] r;
    r = 8'h00;
    r[R1_ILLEGAL] = illegal;
    r[R1_IDLE]    = idle;
    return r;
  endfunction
endpackage

// File: rtl/sd_spi_responder_if.sv
// Byte-wide read port between the responder (master) and the backing memory (slave).
interface sd_spi_responder_if;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;

  modport master (output mem_rd, mem_addr, input mem_ack, mem_data);
  modport slave  (input mem_rd, mem_addr, output mem_ack, mem_data);
endinterface

// File: rtl/sd_spi_responder_byte_slave.sv
// SPI mode-0 byte engine: pin synchronizers, SCLK edge detect, rx/tx shifters.
// tx_byte is latched on tx_load and goes out from the falling edge after the next byte boundary.
module spi_byte_slave (
  input  logic       iCLK,
  input  logic       Reset,
  input  logic       sd_cs,
  input  logic       sd_clk,
  input  logic       sd_mosi,
  output logic       sd_miso,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       cs_abort
);
  logic [1:0] cs_sync_q, clk_sync_q, mosi_sync_q;
  logic       cs_prev_q, clk_prev_q;
  logic [7:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d, tx_buf_q, tx_buf_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       bnd_q, bnd_d, miso_q, miso_d, rx_valid_q, rx_valid_d;
  logic       cs_hi, sclk_rise, sclk_fall;

  assign cs_hi     = cs_sync_q[1];
  assign sclk_rise = clk_sync_q[1] & ~clk_prev_q;
  assign sclk_fall = ~clk_sync_q[1] & clk_prev_q;
  assign cs_abort  = cs_hi & ~cs_prev_q;
  assign sd_miso   = miso_q;
  assign rx_valid  = rx_valid_q;
  assign rx_byte   = rx_sr_q;

  always_comb begin
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    tx_buf_d   = tx_buf_q;
    bit_cnt_d  = bit_cnt_q;
    bnd_d      = bnd_q;
    miso_d     = miso_q;
    rx_valid_d = 1'b0;
    if (cs_hi) begin
      bit_cnt_d = 3'd0;
      bnd_d     = 1'b0;
      tx_sr_d   = 8'hFF;
      tx_buf_d  = 8'hFF;
      miso_d    = 1'b1;
    end else begin
      if (sclk_rise) begin
        rx_sr_d   = {rx_sr_q[6:0], mosi_sync_q[1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_valid_d = 1'b1;
          bnd_d      = 1'b1;
        end
      end
      if (sclk_fall) begin
        // First fall after a boundary starts the next byte; the buffer reverts to idle fill.
        if (bnd_q) begin
          miso_d   = tx_buf_q[7];
          tx_sr_d  = {tx_buf_q[6:0], 1'b1};
          tx_buf_d = 8'hFF;
          bnd_d    = 1'b0;
        end else begin
          miso_d  = tx_sr_q[7];
          tx_sr_d = {tx_sr_q[6:0], 1'b1};
        end
      end
      if (tx_load) tx_buf_d = tx_byte;
    end
  end

  always_ff @(posedge iCLK or negedge Reset) begin
    if (!Reset) begin
      cs_sync_q   <= 2'b11;
      clk_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b11;
      cs_prev_q   <= 1'b1;
      clk_prev_q  <= 1'b0;
      rx_sr_q     <= 8'h00;
      tx_sr_q     <= 8'hFF;
      tx_buf_q    <= 8'hFF;
      bit_cnt_q   <= 3'd0;
      bnd_q       <= 1'b0;
      miso_q      <= 1'b1;
      rx_valid_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], sd_cs};
      clk_sync_q  <= {clk_sync_q[0], sd_clk};
      mosi_sync_q <= {mosi_sync_q[0], sd_mosi};
      cs_prev_q   <= cs_sync_q[1];
      clk_prev_q  <= clk_sync_q[1];
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      tx_buf_q    <= tx_buf_d;
      bit_cnt_q   <= bit_cnt_d;
      bnd_q       <= bnd_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
    end
  end
endmodule

// File: rtl/sd_spi_responder.sv
// SD card (SPI mode) model: command FSM, card flags and single-block read sequencer.
// Every FSM decision is taken at a byte boundary and selects the byte for the next slot.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter bit          BLOCK_ADDR = 1'b1,
  parameter logic [31:0] OCR_VALUE  = 32'hC0FF8000
) (
  input  logic               iCLK,
  input  logic               Reset,
  input  logic               SD_CS,
  input  logic               SD_CLK,
  input  logic               SD_MOSI,
  output logic               SD_MISO,
  sd_spi_responder_if.master mem,
  output logic               oIdle
);
  logic        rx_valid, cs_abort;
  logic [7:0]  rx_byte;
  sd_state_e   state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d, resp_q, resp_d, mem_addr_q, mem_addr_d, base;
  logic [2:0]  rlen_q, rlen_d;
  logic        in_idle_q, in_idle_d, app_q, app_d, pend_q, pend_d, dvld_q, dvld_d;
  logic        mem_rd_q, mem_rd_d, tx_load_q, tx_load_d;
  logic [7:0]  data_q, data_d, tx_byte_q, tx_byte_d;
  logic        illegal, idle_nx;

  spi_byte_slave u_byte (
    .iCLK     (iCLK),
    .Reset    (Reset),
    .sd_cs    (SD_CS),
    .sd_clk   (SD_CLK),
    .sd_mosi  (SD_MOSI),
    .sd_miso  (SD_MISO),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .tx_load  (tx_load_q),
    .tx_byte  (tx_byte_q),
    .cs_abort (cs_abort)
  );

  assign base         = BLOCK_ADDR ? {arg_q[22:0], 9'd0} : arg_q;
  assign mem.mem_rd   = mem_rd_q;
  assign mem.mem_addr = mem_addr_q;
  assign oIdle        = in_idle_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    resp_d     = resp_q;
    rlen_d     = rlen_q;
    in_idle_d  = in_idle_q;
    app_d      = app_q;
    pend_d     = pend_q;
    dvld_d     = dvld_q;
    data_d     = data_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    tx_load_d  = 1'b0;
    tx_byte_d  = 8'hFF;
    illegal    = 1'b0;
    idle_nx    = in_idle_q;

    if (mem.mem_ack && pend_q) begin
      data_d = mem.mem_data;
      dvld_d = 1'b1;
      pend_d = 1'b0;
    end

    if (cs_abort) begin
      state_d = ST_HUNT;
      cnt_d   = 9'd0;
      pend_d  = 1'b0;
      dvld_d  = 1'b0;
      app_d   = 1'b0;
    end else if (rx_valid) begin
      unique case (state_q)
        ST_HUNT: if (rx_byte[7:6] == 2'b01) begin
          cmd_d   = rx_byte[5:0];
          cnt_d   = 9'd0;
          state_d = ST_CMD;
        end
        ST_CMD: begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q[2]) begin
            cnt_d   = 9'd0;
            state_d = ST_NCR;
          end else begin
            arg_d = {arg_q[23:0], rx_byte};
          end
        end
        ST_NCR: begin
          state_d = ST_RESP;
          rlen_d  = 3'd0;
          app_d   = 1'b0;
          if (app_q && cmd_q == ACMD41) begin
            idle_nx = 1'b0;
          end else begin
            case (cmd_q)
              CMD0:  idle_nx = 1'b1;
              CMD8:  begin resp_d = {24'h000001, arg_q[7:0]}; rlen_d = 3'd4; end
              CMD16: illegal = 1'b0;
              CMD55: app_d = 1'b1;
              CMD58: begin resp_d = OCR_VALUE; rlen_d = 3'd4; end
              CMD17: begin
                if (in_idle_q) begin
                  illegal = 1'b1;
                end else begin
                  state_d    = ST_RDWAIT;
                  mem_rd_d   = 1'b1;
                  mem_addr_d = base;
                  pend_d     = 1'b1;
                  dvld_d     = 1'b0;
                end
              end
              default: illegal = 1'b1;
            endcase
          end
          in_idle_d = idle_nx;
          tx_load_d = 1'b1;
          tx_byte_d = r1_byte(illegal, idle_nx);
        end
        ST_RESP: begin
          if (rlen_q != 3'd0) begin
            tx_load_d = 1'b1;
            tx_byte_d = resp_q[31:24];
            resp_d    = {resp_q[23:0], 8'h00};
            rlen_d    = rlen_q - 3'd1;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_RDWAIT: if (dvld_q) begin
          tx_load_d = 1'b1;
          tx_byte_d = DATA_TOKEN;
          state_d   = ST_TOKEN;
        end
        ST_TOKEN: begin
          tx_load_d  = 1'b1;
          tx_byte_d  = data_q;
          cnt_d      = 9'd0;
          state_d    = ST_DATA;
          mem_rd_d   = 1'b1;
          mem_addr_d = base + 32'd1;
          pend_d     = 1'b1;
          dvld_d     = 1'b0;
        end
        ST_DATA: begin
          tx_load_d = 1'b1;
          if (cnt_q == BLK_LAST) begin
            tx_byte_d = 8'h00;
            cnt_d     = 9'd0;
            state_d   = ST_CRC;
          end else begin
            // A late ack leaves data_q holding the previous byte, which is resent.
            tx_byte_d = data_q;
            cnt_d     = cnt_q + 9'd1;
            if (cnt_q < BLK_LAST - 9'd1) begin
              mem_rd_d   = 1'b1;
              mem_addr_d = base + {23'd0, cnt_q} + 32'd2;
              pend_d     = 1'b1;
              dvld_d     = 1'b0;
            end
          end
        end
        ST_CRC: begin
          if (cnt_q == 9'd0) begin
            tx_load_d = 1'b1;
            tx_byte_d = 8'h00;
            cnt_d     = 9'd1;
          end else begin
            cnt_d   = 9'd0;
            state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_HUNT;
      cnt_q      <= 9'd0;
      cmd_q      <= 6'd0;
      arg_q      <= 32'd0;
      resp_q     <= 32'd0;
      rlen_q     <= 3'd0;
      in_idle_q  <= 1'b1;
      app_q      <= 1'b0;
      pend_q     <= 1'b0;
      dvld_q     <= 1'b0;
      data_q     <= 8'h00;
      mem_addr_q <= 32'd0;
      mem_rd_q   <= 1'b0;
      tx_load_q  <= 1'b0;
      tx_byte_q  <= 8'hFF;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      resp_q     <= resp_d;
      rlen_q     <= rlen_d;
      in_idle_q  <= in_idle_d;
      app_q      <= app_d;
      pend_q     <= pend_d;
      dvld_q     <= dvld_d;
      data_q     <= data_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      tx_load_q  <= tx_load_d;
      tx_byte_q  <= tx_byte_d;
    end
  end
endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: SPI host tasks plus a delayed-ack memory model.
module tb_sd_spi_responder;
  localparam int HALF    = 5;
  localparam int ACK_DLY = 20;

  logic iCLK = 1'b0, Reset = 1'b0, SD_CS = 1'b1, SD_CLK = 1'b0, SD_MOSI = 1'b1;
  logic SD_MISO, oIdle;
  int n_vec = 0, n_bad = 0, rd_cnt = 0, rd_base = 0;
  logic [31:0] exp_addr = 32'd0;
  logic [7:0] rsp [0:7];

  sd_spi_responder_if mem_if ();

  sd_spi_responder dut (
    .iCLK    (iCLK),
    .Reset   (Reset),
    .SD_CS   (SD_CS),
    .SD_CLK  (SD_CLK),
    .SD_MOSI (SD_MOSI),
    .SD_MISO (SD_MISO),
    .mem     (mem_if),
    .oIdle   (oIdle)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      SD_MOSI = tx[i];
      repeat (HALF) @(negedge iCLK);
      rx[i]  = SD_MISO;
      SD_CLK = 1'b1;
      repeat (HALF) @(negedge iCLK);
      SD_CLK = 1'b0;
    end
  endtask

  // Sends a 6-byte command then clocks n fill bytes into rsp[0..n-1] (rsp[0] is the NCR slot).
  task automatic do_cmd(input logic [7:0] c, input logic [31:0] arg, input logic [7:0] crc, input int n);
    logic [7:0] b;
    logic [47:0] f;
    f = {c, arg, crc};
    for (int i = 5; i >= 0; i--) spi_xfer(f[i*8 +: 8], b);
    for (int i = 0; i < n; i++) begin
      spi_xfer(8'hFF, b);
      rsp[i] = b;
    end
  endtask

  task automatic chk_seq(input string tag, input int n, input logic [63:0] exp);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", tag, i), {24'd0, rsp[i]}, {24'd0, exp[8*(n-1-i) +: 8]});
  endtask

  task automatic read_token(input string tag);
    logic [7:0] b;
    int fill;
    fill = 0;
    spi_xfer(8'hFF, b);
    while (b == 8'hFF && fill < 8) begin
      fill++;
      spi_xfer(8'hFF, b);
    end
    chk(tag, {24'd0, b}, 32'hFE);
  endtask

  // Memory: data = addr[7:0], ack ACK_DLY cycles after each request; addresses must be sequential.
  initial begin
    logic [31:0] a;
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_data = 8'h00;
    forever begin
      @(negedge iCLK);
      if (mem_if.mem_rd === 1'b1) begin
        a = mem_if.mem_addr;
        rd_cnt++;
        chk("mem_addr", a, exp_addr);
        exp_addr = exp_addr + 32'd1;
        repeat (ACK_DLY - 1) @(negedge iCLK);
        mem_if.mem_ack  = 1'b1;
        mem_if.mem_data = a[7:0];
        @(negedge iCLK);
        mem_if.mem_ack  = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] b;
    repeat (4) @(negedge iCLK);
    chk("rst_miso", {31'd0, SD_MISO}, 32'd1);
    chk("rst_rd", {31'd0, mem_if.mem_rd}, 32'd0);
    chk("rst_addr", mem_if.mem_addr, 32'd0);
    chk("rst_idle", {31'd0, oIdle}, 32'd1);
    Reset = 1'b1;
    repeat (4) @(negedge iCLK);
    SD_CS = 1'b0;
    repeat (4) @(negedge iCLK);
    spi_xfer(8'hFF, b);
    chk("hunt_ff", {24'd0, b}, 32'hFF);

    do_cmd(8'h51, 32'd3, 8'hFF, 3);
    chk_seq("cmd17_idle", 3, 64'hFF_05_FF);
    chk("cmd17_idle_rd", rd_cnt, 0);

    do_cmd(8'h40, 32'd0, 8'h95, 2);
    chk_seq("cmd0", 2, 64'hFF_01);
    chk("cmd0_idle", {31'd0, oIdle}, 32'd1);

    do_cmd(8'h48, 32'h000001AA, 8'h87, 6);
    chk_seq("cmd8", 6, 64'hFF_01_00_00_01_AA);

    do_cmd(8'h77, 32'd0, 8'h65, 2);
    chk_seq("cmd55", 2, 64'hFF_01);
    do_cmd(8'h69, 32'h40000000, 8'h77, 2);
    chk_seq("acmd41", 2, 64'hFF_00);
    chk("acmd41_idle", {31'd0, oIdle}, 32'd0);

    do_cmd(8'h7A, 32'd0, 8'hFD, 6);
    chk_seq("cmd58", 6, 64'hFF_00_C0_FF_80_00);

    exp_addr = 32'h600;
    rd_base  = rd_cnt;
    do_cmd(8'h51, 32'd3, 8'hFF, 2);
    chk_seq("cmd17_r1", 2, 64'hFF_00);
    read_token("cmd17_token");
    for (int i = 0; i < 512; i++) begin
      spi_xfer(8'hFF, b);
      chk($sformatf("blk_data[%0d]", i), {24'd0, b}, i & 32'hFF);
    end
    spi_xfer(8'hFF, b);
    chk("blk_crc0", {24'd0, b}, 32'h00);
    spi_xfer(8'hFF, b);
    chk("blk_crc1", {24'd0, b}, 32'h00);
    chk("blk_rd_cnt", rd_cnt - rd_base, 512);
    chk("blk_addr_end", exp_addr, 32'h800);

    exp_addr = 32'h0;
    rd_base  = rd_cnt;
    do_cmd(8'h51, 32'd0, 8'hFF, 2);
    chk_seq("abort_r1", 2, 64'hFF_00);
    read_token("abort_token");
    for (int i = 0; i < 100; i++) begin
      spi_xfer(8'hFF, b);
      chk($sformatf("abort_data[%0d]", i), {24'd0, b}, i);
    end
    repeat (2) @(negedge iCLK);
    SD_CS = 1'b1;
    repeat (6) @(negedge iCLK);
    chk("abort_miso", {31'd0, SD_MISO}, 32'd1);
    repeat (300) @(negedge iCLK);
    chk("abort_rd_cnt", rd_cnt - rd_base, 102);
    chk("abort_idle", {31'd0, oIdle}, 32'd0);
    SD_CS = 1'b0;
    repeat (4) @(negedge iCLK);
    do_cmd(8'h40, 32'd0, 8'h95, 2);
    chk_seq("post_abort_cmd0", 2, 64'hFF_01);
    chk("post_abort_idle", {31'd0, oIdle}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sd_spi_responder.md
# sd_spi_responder

SPI-mode SD card responder: the card end of the SD/SPI link that our bus-side SD master drives. It decodes SD commands on SD_CS/SD_CLK/SD_MOSI, answers on SD_MISO, and serves single-block reads from a byte-wide memory port. It is used as an on-chip card model so the processor's SD path can run in simulation and on boards without a card.

## Interface
- BLOCK_ADDR, default 1: 1 gives SDHC block addressing (byte address = arg<<9); 0 uses arg as the byte address.
- OCR_VALUE, default 32'hC0FF8000: the OCR returned by CMD58.
- iCLK  in  1  system clock; oversamples the SPI pins.
- Reset  in  1  asynchronous, active-low reset.
- SD_CS  in  1  chip select, active-low.
- SD_CLK  in  1  SPI clock, mode 0.
- SD_MOSI  in  1  command data from the master.
- SD_MISO  out  1  response data to the master.
- mem_rd  out  1  single-cycle read request.
- mem_addr  out  32  byte address for the read.
- mem_ack  in  1  read data valid this cycle.
- mem_data  in  8  read data.
- oIdle  out  1  card is in the idle state (the in_idle flag).

## Operation
- SD_CS, SD_CLK and SD_MOSI pass through two-flop synchronizers into SCLK edge detectors.
- While SD_CS is low:
  - MOSI is sampled on rising edges, MSB first.
  - A byte completes on the 8th rising edge.
  - MISO changes on falling edges. The next byte's MSB is driven on the falling edge that follows the previous byte's 8th rising edge.
- When the block is not transmitting, or SD_CS is high, SD_MISO is 1. The transmit byte defaults to 0xFF.
- States:
  - HUNT: wait for a byte with bits[7:6]=01.
  - CMD: collect 4 argument bytes and 1 CRC byte. The CRC is ignored.
  - NCR: send one 0xFF.
  - RESP: send R1, then any trailer bytes.
  - RDWAIT: hold while the first memory byte is pending.
  - TOKEN, DATA, CRC: see CMD17 below.
  - Every path returns to HUNT.
- R1 = {0, 0, 0, 0, 0, illegal, 0, in_idle}. in_idle is set by reset and by CMD0.
- Command handling:
  - CMD0: R1 0x01.
  - CMD8: R1, then 00 00 01 and arg[7:0] echoed.
  - CMD55: R1; sets the app flag for exactly the next command.
  - ACMD41: clears in_idle; R1 0x00.
  - CMD58: R1, then OCR_VALUE MSB first.
  - CMD16: R1; the argument is ignored.
  - CMD17 with in_idle=0:
    - R1 0x00, then 0xFF fill bytes until byte 0 of the block is acked.
    - Then token 0xFE, 512 data bytes, and 2 CRC bytes of 0x00.
    - Byte n is requested at address base+n. The request for n+1 is issued when byte n is loaded into the shifter.
  - CMD17 with in_idle=1: R1 0x05; no token and no mem_rd.
  - Any other command (including CMD41 without a preceding CMD55): R1 = 0x04 | in_idle.
- SD_CS rising at any point aborts the transfer:
  - State returns to HUNT and the bit counter clears.
  - A pending mem_ack is discarded and no further mem_rd is issued.
  - in_idle is kept and the app flag is cleared.
- Bytes arriving on MOSI during a response are ignored.

## Timing
- Reset values: SD_MISO=1, mem_rd=0, mem_addr=0, oIdle=1, state HUNT, counters 0.
- SD_CLK high and low phases must each be ≥4 iCLK cycles.
- Pin-edge-to-MISO-update latency is ≤4 iCLK cycles.
- mem_rd is high for one cycle. At most one request is outstanding at a time.
- Memory constraint:
  - mem_ack for bytes 1..511 must arrive within 8 SCLK bit times of the request.
  - A late ack is a protocol error; the block transmits the previous data byte again. Verification flags this as a violation.
- mem_addr is held stable from mem_rd until mem_ack.
- Data byte counter is 9 bits and saturates at 511 → CRC.
- mem_addr = base + counter, computed as 32-bit, wrapping modulo 2^32.
- A new command's first byte is accepted in the byte slot immediately after the last response byte.

## Structure
- Package sd_spi_pkg holds:
  - command indices CMD0/8/16/17/55/58 and ACMD41;
  - R1 bit positions;
  - DATA_TOKEN=8'hFE;
  - the state enum.
- Sub-module spi_byte_slave holds:
  - synchronizers and edge detect;
  - rx/tx shift registers and bit counter;
  - rx_valid/rx_byte output strobe;
  - tx_load/tx_byte input;
  - cs_abort strobe.
- The top level contains the command FSM, card flags and memory sequencer.

## Test plan
- CMD0 (40 00000000 95) → one 0xFF, then R1 0x01; oIdle=1.
- CMD8 (48 000001AA 87) → FF, then 01 00 00 01 AA.
- CMD55 then ACMD41 → 01, then 00; oIdle=0. Then CMD58 → 00 C0 FF 80 00.
- After init, CMD17 arg 3 with memory data=addr[7:0] and ack delayed by 20 cycles:
  - mem_addr sweeps 0x600..0x7FF;
  - MISO sends 00, FF fill, FE, 00..FF, 00..FF, 00 00.
- CMD17 straight after reset → R1 0x05; no FE token; mem_rd never asserted.
- SD_CS raised after 100 data bytes → MISO=1, no further mem_rd. A following CMD0 → 0x01.
